// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared types and default widths for the data-memory arbiter.
// Revision 1.0
`default_nettype none

package dmem_arb_pkg;

   localparam int unsigned ADDR_W_DEF       = 32;
   localparam int unsigned DATA_W_DEF       = 32;
   localparam int unsigned STARVE_LIMIT_DEF = 4;

   typedef enum logic [0:0] {
      CORE_PRI  = 1'b0,
      EXT_FORCE = 1'b1
   } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: core, external-requester and data-memory bus around the arbiter.
// Revision 1.0
`default_nettype none

interface dmem_arbiter_if
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) ();

   logic              core_req;
   logic              core_we;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic [DATA_W-1:0] core_rdata;
   logic              core_stall;

   logic              ext_req;
   logic              ext_we;
   logic [ADDR_W-1:0] ext_addr;
   logic [DATA_W-1:0] ext_wdata;
   logic              ext_gnt;
   logic              ext_rvalid;
   logic [DATA_W-1:0] ext_rdata;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Arbiter side.
   modport slave (
      input  core_req, core_we, core_addr, core_wdata,
      output core_rdata, core_stall,
      input  ext_req, ext_we, ext_addr, ext_wdata,
      output ext_gnt, ext_rvalid, ext_rdata,
      output mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   // Requesters plus memory side.
   modport master (
      output core_req, core_we, core_addr, core_wdata,
      input  core_rdata, core_stall,
      output ext_req, ext_we, ext_addr, ext_wdata,
      input  ext_gnt, ext_rvalid, ext_rdata,
      input  mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: single-port data-memory arbiter, core fixed priority with ext starvation guard.
// Revision 1.0
`default_nettype none

module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned DATA_W       = DATA_W_DEF,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic           clk,
   input  logic           rst,
   dmem_arbiter_if.slave  bus
);

   localparam int unsigned       CNT_W    = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STARVE_LIMIT - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic [CNT_W-1:0]  r_starve_cnt;
   logic [CNT_W-1:0]  w_starve_cnt_nxt;
   logic              r_ext_rvalid;
   logic [DATA_W-1:0] r_ext_rdata;

   logic              w_ext_gnt;
   logic              w_core_gnt;
   logic              w_deny;
   logic              w_ext_rd;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;

   // Grant decision and next-state; the counter clears whenever no denial happens.
   always_comb begin
      w_state_nxt      = CORE_PRI;
      w_starve_cnt_nxt = '0;
      w_ext_gnt        = 1'b0;
      w_deny           = 1'b0;
      case (r_state)
         CORE_PRI: begin
            w_ext_gnt = bus.ext_req & ~bus.core_req;
            w_deny    = bus.ext_req &  bus.core_req;
         end
         EXT_FORCE: begin
            w_ext_gnt = bus.ext_req;
         end
         default: begin
            w_ext_gnt = 1'b0;
         end
      endcase
      w_core_gnt = bus.core_req & ~w_ext_gnt;
      if (w_deny) begin
         if (r_starve_cnt == CNT_LAST) begin
            w_state_nxt = EXT_FORCE;
         end else begin
            w_starve_cnt_nxt = r_starve_cnt + CNT_ONE;
         end
      end
   end

   // Idle cycles keep the core address on the bus so the read path stays quiet.
   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_addr  = bus.core_addr;
      w_mem_wdata = bus.core_wdata;
      if (w_ext_gnt) begin
         w_mem_we    = bus.ext_we;
         w_mem_addr  = bus.ext_addr;
         w_mem_wdata = bus.ext_wdata;
      end else if (w_core_gnt) begin
         w_mem_we    = bus.core_we;
      end
   end

   assign w_ext_rd = w_ext_gnt & ~bus.ext_we;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= CORE_PRI;
         r_starve_cnt <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_starve_cnt <= w_starve_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ext_rvalid <= 1'b0;
         r_ext_rdata  <= '0;
      end else begin
         r_ext_rvalid <= w_ext_rd;
         if (w_ext_rd) begin
            r_ext_rdata <= bus.mem_rdata;
         end
      end
   end

   assign bus.mem_we     = w_mem_we;
   assign bus.mem_addr   = w_mem_addr;
   assign bus.mem_wdata  = w_mem_wdata;
   assign bus.core_rdata = bus.mem_rdata;
   assign bus.core_stall = bus.core_req & ~w_core_gnt;
   assign bus.ext_gnt    = w_ext_gnt;
   assign bus.ext_rvalid = r_ext_rvalid;
   assign bus.ext_rdata  = r_ext_rdata;

   a_one_grant : assert property (@(posedge clk) disable iff (!rst)
      !(w_ext_gnt && w_core_gnt));

   a_we_needs_grant : assert property (@(posedge clk) disable iff (!rst)
      w_mem_we |-> (w_ext_gnt || w_core_gnt));

endmodule

`default_nettype wire
